// File: rtl/bsu_chan_seq.sv
// Beam steering unit channel selector: decodes a select code to a registered one-hot
// phase-shifter enable, or autonomously scans all channels with a programmable dwell.
module bsu_chan_seq #(
    parameter int unsigned NCH    = 7,
    parameter int unsigned SELW   = 5,
    parameter int unsigned BASE   = 6,
    parameter int unsigned STEP   = 2,
    parameter int unsigned DWELLW = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       mode,
    input  logic [SELW-1:0]            sel,
    input  logic                       sel_vld,
    input  logic [DWELLW-1:0]          dwell,
    input  logic                       start,
    input  logic                       abort,
    output logic [NCH-1:0]             f,
    output logic [$clog2(NCH+1)-1:0]   cur_ch,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned CHW = $clog2(NCH + 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            state_q;
    logic [DWELLW-1:0] cnt_q;
    logic [DWELLW-1:0] dwell_q;

    logic [SELW:0]     off;
    logic [31:0]       offw;
    logic [31:0]       quot;
    logic              code_ok;
    logic [DWELLW-1:0] dwell_eff;

    // The extra top bit of off is the borrow of sel - BASE.
    always_comb begin
        off       = {1'b0, sel} - (SELW + 1)'(BASE);
        offw      = 32'(off[SELW-1:0]);
        quot      = offw / STEP;
        code_ok   = !off[SELW] && (offw % STEP == 0) && (quot < NCH);
        dwell_eff = (dwell == '0) ? DWELLW'(1) : dwell;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dwell_q <= '0;
            f       <= '0;
            cur_ch  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (!en) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                f       <= '0;
                cur_ch  <= '0;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && mode && !abort) begin
                            state_q <= StScan;
                            dwell_q <= dwell_eff;
                            cnt_q   <= '0;
                            f       <= NCH'(1);
                            cur_ch  <= CHW'(1);
                            busy    <= 1'b1;
                        end else if (sel_vld) begin
                            if (code_ok) begin
                                f      <= NCH'(1) << quot;
                                cur_ch <= CHW'(quot + 1);
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    StScan: begin
                        if (abort) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            f       <= '0;
                            cur_ch  <= '0;
                            busy    <= 1'b0;
                        end else if (cnt_q == dwell_q - DWELLW'(1)) begin
                            cnt_q <= '0;
                            if (cur_ch == CHW'(NCH)) begin
                                state_q <= StIdle;
                                f       <= '0;
                                cur_ch  <= '0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                f      <= f << 1;
                                cur_ch <= cur_ch + CHW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + DWELLW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
